sram_mem_stage: RTL and testbench
=================================

Name: sram_mem_stage

Overview:
- Memory-stage controller upstream of the MEM/WB pipeline register.
- Turns one 32-bit load/store from EXE/MEM into two 16-bit accesses on the off-chip SRAM.
- Returns load data to the MEM/WB register's memory-read-value input.
- Drops `ready` while an access is in flight; the hazard/pipeline logic uses `~ready` as the global freeze.

Parameters:
- ADDR_BASE, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 3: cycles per 16-bit SRAM phase. Legal range is 2..15.
- SRAM_AW, 18: SRAM address width.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  reset; synchronous, active-low
- wr_en  input  1  store request from EXE/MEM
- rd_en  input  1  load request from EXE/MEM
- address  input  32  byte address from the ALU result
- write_data  input  32  store data (Val_Rm)
- read_data  output  32  load data to MEM/WB
- ready  output  1  high when no access is pending or the access is complete
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_ADDR  output  SRAM_AW  SRAM half-word address
- SRAM_WE_N  output  1  write strobe, active-low
- SRAM_OE_N  output  1  output enable, active-low
- SRAM_CE_N  output  1  chip enable; tied 0
- SRAM_UB_N  output  1  upper byte enable; tied 0
- SRAM_LB_N  output  1  lower byte enable; tied 0

Behaviour:
- All sequential logic updates on posedge clk.
- rst==0 at an edge:
  - state=IDLE, cnt=0, read_data=0.
  - Outputs after reset: SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ=Z, SRAM_ADDR=0.
  - Reset applies mid-operation; any half-completed access is abandoned.
- Address translation:
  - w = (address - ADDR_BASE) >> 2, truncated to SRAM_AW-1 bits.
  - Low phase uses SRAM_ADDR = {w,0}; high phase uses {w,1}.
  - Low half-word is bits [15:0]; high half-word is bits [31:16].
  - No range check; out-of-range addresses wrap modulo SRAM size.
- Request: req = wr_en | rd_en. If both are asserted, the access is a write.
- ready = ~req | (state==DONE). This is combinational, so ready is 1 in IDLE with no request.
- States and transitions:
  - IDLE: if req, capture op (write/read) and go to LOW with cnt=0.
  - LOW: lasts WAIT_CYCLES cycles; cnt increments each cycle. At cnt==WAIT_CYCLES-1, go to HIGH with cnt=0.
  - HIGH: same timing as LOW, then go to DONE.
  - DONE: exactly 1 cycle, then unconditionally IDLE. Freeze is released here, so the pipeline advances at the end of DONE.
- Latency:
  - Request first seen in IDLE at cycle 0.
  - ready=0 for cycles 0..2*WAIT_CYCLES; ready=1 at cycle 2*WAIT_CYCLES+1 (DONE).
  - Default WAIT_CYCLES=3: 7 freeze cycles, ready at cycle 7.
- Write phases (LOW and HIGH):
  - SRAM_DQ drives the corresponding write_data half for the whole phase.
  - SRAM_WE_N=0 for cnt<WAIT_CYCLES-1 and 1 on the last phase cycle, giving address/data hold.
  - SRAM_OE_N=1.
- Read phases:
  - SRAM_DQ=Z, SRAM_OE_N=0, SRAM_WE_N=1.
  - On the last cycle of LOW, read_data[15:0] is registered from SRAM_DQ.
  - On the last cycle of HIGH, read_data[31:16] is registered from SRAM_DQ.
- IDLE and DONE: SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ=Z, SRAM_ADDR holds its last value.
- read_data holds until the next read capture; writes never modify it.
- Request deasserted mid-access (illegal, because the pipeline is frozen): the access still completes.
- Back-to-back requests: a new request present in the IDLE cycle after DONE starts a fresh access. There is no idle gap beyond the IDLE cycle itself.

Test Plan:
- Reset, then no requests for 10 cycles -> ready=1 throughout, read_data=0, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ=Z.
- wr_en=1, address=1024, write_data=0xDEADBEEF -> SRAM model holds 0xBEEF at half-address 0 and 0xDEAD at half-address 1. SRAM_WE_N is low for 2 cycles in each phase. ready first rises at cycle 7.
- Then rd_en=1, address=1024 -> SRAM_OE_N=0 during LOW and HIGH; ready at cycle 7; read_data=0xDEADBEEF in DONE and held afterwards.
- wr_en=1 and rd_en=1 together, address=1028, write_data=0x12345678 -> treated as a write. SRAM half-addresses 2 and 3 receive 0x5678 and 0x1234. read_data unchanged.
- rst=0 at cycle 3 of a read -> next cycle: state IDLE, read_data=0, SRAM_OE_N=1. After rst=1, with rd_en still high, a full 7-cycle read restarts.
- Back-to-back reads of 1024 then 1028 -> two separate 7-cycle freeze windows separated only by the single DONE cycle. read_data shows each word in its own DONE cycle.

Source files
------------

// File: rtl/sram_mem_stage.sv
// Memory-stage controller: splits one 32-bit load/store into two 16-bit SRAM
// phases (low half-word, then high) and freezes the pipeline via ready meanwhile.
module sram_mem_stage #(
  parameter int ADDR_BASE   = 1024,
  parameter int WAIT_CYCLES = 3,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, DONE = 2'd3} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 is_wr_q, is_wr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [SRAM_AW-1:0]   addr_q, addr_d;

  logic                 req;
  logic                 last;
  logic                 in_phase;
  logic                 dq_oe;
  logic [15:0]          dq_out;
  logic [SRAM_AW-2:0]   word_idx;

  // Word index wraps modulo the SRAM size; there is no range check.
  assign word_idx = (SRAM_AW-1)'((address - 32'(ADDR_BASE)) >> 2);
  assign req      = wr_en | rd_en;
  assign last     = (cnt_q == LAST);
  assign in_phase = (state_q == LOW) || (state_q == HIGH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LOW;
          cnt_d   = 4'd0;
          is_wr_d = wr_en;
          wdata_d = write_data;
          addr_d  = {word_idx, 1'b0};
        end
      end
      LOW: begin
        if (last) begin
          state_d = HIGH;
          cnt_d   = 4'd0;
          addr_d  = {addr_q[SRAM_AW-1:1], 1'b1};
          if (!is_wr_q) rdata_d[15:0] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HIGH: begin
        if (last) begin
          state_d = DONE;
          cnt_d   = 4'd0;
          if (!is_wr_q) rdata_d[31:16] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      is_wr_q <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
    end
  end

  // WE_N rises on the last cycle of each write phase so address/data are held past the strobe.
  always_comb begin
    SRAM_WE_N = ~(in_phase & is_wr_q & ~last);
    SRAM_OE_N = ~(in_phase & ~is_wr_q);
    dq_oe     = in_phase & is_wr_q;
    dq_out    = (state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
  end

  assign SRAM_DQ     = dq_oe ? dq_out : 16'hzzzz;
  assign SRAM_ADDR   = addr_q;
  assign SRAM_CE_N   = 1'b0;
  assign SRAM_UB_N   = 1'b0;
  assign SRAM_LB_N   = 1'b0;
  assign read_data   = rdata_q;
  assign ready       = ~req | (state_q == DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_mem_stage.sv
// Bench for sram_mem_stage: directed vector table, reset/back-to-back sequences,
// and random load/store traffic against a word-level memory reference model.
module tb_sram_mem_stage;

  localparam int WAITC  = 3;
  localparam int EXP_RDY = 2 * WAITC + 1;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N;
  logic        SRAM_OE_N;
  logic        SRAM_CE_N;
  logic        SRAM_UB_N;
  logic        SRAM_LB_N;
  logic [1:0]  dbg_state;

  sram_mem_stage #(.ADDR_BASE(1024), .WAIT_CYCLES(WAITC), .SRAM_AW(18)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // off-chip SRAM device model
  logic [15:0] sram [0:(1<<18)-1];
  assign SRAM_DQ = (!SRAM_OE_N && SRAM_WE_N) ? sram[SRAM_ADDR] : 16'hzzzz;
  always @(posedge clk) if (!SRAM_WE_N) sram[SRAM_ADDR] <= SRAM_DQ;

  // scoreboard state
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] ref_mem [int];
  logic [31:0] exp_q [$];
  logic [31:0] exp_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'(((a - 32'd1024) >> 2) % 32'd131072);
  endfunction

  function automatic logic [31:0] ref_read(input int w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return 32'd0;
  endfunction

  // driver: one access, observed from its IDLE cycle (cycle 0) to the ready cycle
  task automatic run_access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                            output int rdy_at, output int we_low, output int oe_low,
                            output logic [17:0] a_lo, output logic [17:0] a_hi,
                            output logic [31:0] rdata);
    @(negedge clk);
    wr_en = w; rd_en = r; address = a; write_data = d;
    #1;
    rdy_at = -1; we_low = 0; oe_low = 0; a_lo = '0; a_hi = '0; rdata = '0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (!SRAM_WE_N) we_low++;
      if (!SRAM_OE_N) oe_low++;
      if (c == 1) a_lo = SRAM_ADDR;
      if (c == WAITC + 1) a_hi = SRAM_ADDR;
      if (ready) begin rdy_at = c; rdata = read_data; break; end
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input logic [31:0] exp_rdata);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0;
      #1;
      check("idle ready", 32'(ready), 32'd1);
      check("idle read_data", read_data, exp_rdata);
      check("idle we_n", 32'(SRAM_WE_N), 32'd1);
      check("idle oe_n", 32'(SRAM_OE_N), 32'd1);
    end
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_we;
    int          exp_oe;
    logic [17:0] exp_alo;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int          rdy_at, we_low, oe_low;
    logic [17:0] a_lo, a_hi, exp_ahi;
    logic [31:0] rdata, a, d;
    logic        w, r;
    int          sel;

    vecs[0] = '{1'b1, 1'b0, 32'd1024,   32'hDEADBEEF, 32'h00000000, 4, 0, 18'h00000};
    vecs[1] = '{1'b0, 1'b1, 32'd1024,   32'h00000000, 32'hDEADBEEF, 0, 6, 18'h00000};
    vecs[2] = '{1'b1, 1'b1, 32'd1028,   32'h12345678, 32'hDEADBEEF, 4, 0, 18'h00002};
    vecs[3] = '{1'b0, 1'b1, 32'd1028,   32'h00000000, 32'h12345678, 0, 6, 18'h00002};
    vecs[4] = '{1'b1, 1'b0, 32'd1020,   32'hA5A55A5A, 32'h12345678, 4, 0, 18'h3FFFE};
    vecs[5] = '{1'b0, 1'b1, 32'd1020,   32'h00000000, 32'hA5A55A5A, 0, 6, 18'h3FFFE};
    vecs[6] = '{1'b1, 1'b0, 32'd525312, 32'h0BADF00D, 32'hA5A55A5A, 4, 0, 18'h00000};
    vecs[7] = '{1'b0, 1'b1, 32'd1024,   32'h00000000, 32'h0BADF00D, 0, 6, 18'h00000};

    for (int i = 0; i < (1 << 18); i++) sram[i] = 16'h0000;

    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // reset state and quiet bus with no requests
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("reset state", 32'(dbg_state), 32'd0);
      check("reset sram_addr", 32'(SRAM_ADDR), 32'd0);
    end
    idle_cycles(2, 32'd0);

    // directed vector table, applied back to back
    for (int i = 0; i < 8; i++) begin
      run_access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata,
                 rdy_at, we_low, oe_low, a_lo, a_hi, rdata);
      exp_ahi = {vecs[i].exp_alo[17:1], 1'b1};
      check($sformatf("vec%0d ready_at", i), 32'(rdy_at), 32'(EXP_RDY));
      check($sformatf("vec%0d read_data", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d we_low", i), 32'(we_low), 32'(vecs[i].exp_we));
      check($sformatf("vec%0d oe_low", i), 32'(oe_low), 32'(vecs[i].exp_oe));
      check($sformatf("vec%0d addr_lo", i), 32'(a_lo), 32'(vecs[i].exp_alo));
      check($sformatf("vec%0d addr_hi", i), 32'(a_hi), 32'(exp_ahi));
      if (vecs[i].wr) ref_mem[word_of(vecs[i].addr)] = vecs[i].wdata;
    end
    idle_cycles(2, 32'h0BADF00D);
    check("sram h2", 32'(sram[2]), 32'h5678);
    check("sram h3", 32'(sram[3]), 32'h1234);
    check("sram wrap lo", 32'(sram[18'h3FFFE]), 32'h5A5A);
    check("sram wrap hi", 32'(sram[18'h3FFFF]), 32'hA5A5);
    check("sram h0", 32'(sram[0]), 32'hF00D);
    check("sram h1", 32'(sram[1]), 32'h0BAD);

    // reset during cycle 3 of a read, then the held request restarts it
    @(negedge clk);
    rd_en = 1'b1; address = 32'd1024;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    check("midrst state", 32'(dbg_state), 32'd0);
    check("midrst read_data", read_data, 32'd0);
    check("midrst oe_n", 32'(SRAM_OE_N), 32'd1);
    check("midrst ready", 32'(ready), 32'd0);
    rdy_at = -1;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk); #1;
      if (ready) begin rdy_at = c; break; end
    end
    check("midrst restart ready_at", 32'(rdy_at), 32'(EXP_RDY));
    check("midrst restart read_data", read_data, 32'h0BADF00D);
    rd_en = 1'b0;

    // back-to-back reads separated only by DONE and one IDLE cycle
    run_access(1'b0, 1'b1, 32'd1024, 32'd0, rdy_at, we_low, oe_low, a_lo, a_hi, rdata);
    check("b2b0 ready_at", 32'(rdy_at), 32'(EXP_RDY));
    check("b2b0 read_data", rdata, 32'h0BADF00D);
    run_access(1'b0, 1'b1, 32'd1028, 32'd0, rdy_at, we_low, oe_low, a_lo, a_hi, rdata);
    check("b2b1 ready_at", 32'(rdy_at), 32'(EXP_RDY));
    check("b2b1 read_data", rdata, 32'h12345678);
    idle_cycles(3, 32'h12345678);
    exp_rd = 32'h12345678;

    // random traffic against the word-level reference memory
    for (int t = 0; t < 60; t++) begin
      sel = $urandom_range(0, 2);
      w = (sel != 1);
      r = (sel != 0);
      a = 32'd1024 + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3))
          + (($urandom_range(0, 7) == 0) ? 32'd524288 : 32'd0);
      d = $urandom;
      if (w) ref_mem[word_of(a)] = d;
      else exp_rd = ref_read(word_of(a));
      exp_q.push_back(exp_rd);
      run_access(w, r, a, d, rdy_at, we_low, oe_low, a_lo, a_hi, rdata);
      check($sformatf("rnd%0d ready_at", t), 32'(rdy_at), 32'(EXP_RDY));
      check($sformatf("rnd%0d read_data", t), rdata, exp_q.pop_front());
      check($sformatf("rnd%0d we_low", t), 32'(we_low), w ? 32'd4 : 32'd0);
      check($sformatf("rnd%0d addr_lo", t), 32'(a_lo), 32'(2 * word_of(a)));
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2), exp_rd);
    end
    idle_cycles(1, exp_rd);

    foreach (ref_mem[k])
      check($sformatf("sram word %0d", k), {sram[2*k+1], sram[2*k]}, ref_mem[k]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
